// File: rtl/aes0_cmd_initiator_if.sv
// AXI4-Lite bus between the aes0 job initiator (master) and the aes0 register port (slave).
// Signal suffixes are named from the initiator's point of view.
interface aes0_cmd_initiator_if #(
  parameter int AXI_ADDR_WIDTH = 64
);
  logic                      aw_valid_o;
  logic                      aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_o;
  logic                      w_valid_o;
  logic                      w_ready_i;
  logic [63:0]               w_data_o;
  logic [7:0]                w_strb_o;
  logic                      b_valid_i;
  logic                      b_ready_o;
  logic [1:0]                b_resp_i;
  logic                      ar_valid_o;
  logic                      ar_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_o;
  logic                      r_valid_i;
  logic                      r_ready_o;
  logic [63:0]               r_data_i;
  logic [1:0]                r_resp_i;

  modport master (
    output aw_valid_o, aw_addr_o, w_valid_o, w_data_o, w_strb_o, b_ready_o,
           ar_valid_o, ar_addr_o, r_ready_o,
    input  aw_ready_i, w_ready_i, b_valid_i, b_resp_i, ar_ready_i, r_valid_i,
           r_data_i, r_resp_i
  );

  modport slave (
    input  aw_valid_o, aw_addr_o, w_valid_o, w_data_o, w_strb_o, b_ready_o,
           ar_valid_o, ar_addr_o, r_ready_o,
    output aw_ready_i, w_ready_i, b_valid_i, b_resp_i, ar_ready_i, r_valid_i,
           r_data_i, r_resp_i
  );
endinterface

// File: rtl/aes0_cmd_initiator.sv
// Runs one AES-192 job on the aes0 register map: 16 setup writes, ct_valid polling,
// four result reads and a start-clear write, one AXI4-Lite transaction at a time.
module aes0_cmd_initiator #(
  parameter int                      AXI_ADDR_WIDTH = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                      POLL_MAX       = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         job_valid_i,
  output logic         job_ready_o,
  input  logic [1:0]   key_sel_i,
  input  logic [191:0] key_i,
  input  logic [127:0] state_i,
  input  logic [127:0] pt_i,
  output logic         done_o,
  output logic [1:0]   err_o,
  output logic [127:0] ct_o,
  aes0_cmd_initiator_if.master bus
);
  localparam logic [3:0] S_IDLE = 4'd0, S_WR_REQ = 4'd1, S_WR_RESP = 4'd2,
                         S_POLL_REQ = 4'd3, S_POLL_RESP = 4'd4, S_RD_REQ = 4'd5,
                         S_RD_RESP = 4'd6, S_CLR_REQ = 4'd7, S_CLR_RESP = 4'd8,
                         S_DONE = 4'd9;
  localparam int PCW = $clog2(POLL_MAX + 1) + 1;

  logic [3:0]     r_state, r_idx;
  logic [1:0]     r_rd_idx, r_key_sel, r_err;
  logic [PCW-1:0] r_poll_cnt;
  logic           r_aw_done, r_w_done;
  logic [191:0]   r_key;
  logic [127:0]   r_st, r_pt, r_ct_buf, r_ct;

  logic           w_wr, w_clr, w_both;
  logic [5:0]     w_reg, w_kbase, w_rd_reg;
  logic [3:0]     w_k;
  logic [31:0]    w_word;
  logic           w_unused;

  assign w_clr  = (r_state == S_CLR_REQ) || (r_state == S_CLR_RESP);
  assign w_wr   = (r_state == S_WR_REQ) || (r_state == S_CLR_REQ);
  // AW and W complete independently; the step is done once both have handshaken.
  assign w_both = w_wr && (r_aw_done || bus.aw_ready_i) && (r_w_done || bus.w_ready_i);
  assign w_kbase = (r_key_sel == 2'b00) ? 6'd5 : (r_key_sel == 2'b01) ? 6'd20 : 6'd26;

  always_comb begin
    w_reg  = '0;
    w_word = '0;
    w_k    = '0;
    if (w_clr) begin
      w_reg  = 6'd0;
      w_word = 32'd0;
    end else if (r_idx == 4'd0) begin
      w_reg  = 6'd32;
      w_word = {30'b0, r_key_sel};
    end else if (r_idx <= 4'd6) begin
      w_k    = r_idx - 4'd1;
      w_reg  = w_kbase + {2'b0, w_k};
      w_word = r_key[32*w_k +: 32];
    end else if (r_idx <= 4'd10) begin
      w_k    = r_idx - 4'd7;
      w_reg  = 6'd16 + {2'b0, w_k};
      w_word = r_st[32*w_k +: 32];
    end else if (r_idx <= 4'd14) begin
      w_k    = r_idx - 4'd11;
      w_reg  = 6'd1 + {2'b0, w_k};
      w_word = r_pt[32*w_k +: 32];
    end else begin
      w_reg  = 6'd0;
      w_word = 32'd1;
    end
  end

  assign w_rd_reg = (r_state == S_POLL_REQ) ? 6'd11 : 6'd12 + {4'b0, r_rd_idx};

  assign bus.aw_valid_o = w_wr && !r_aw_done;
  assign bus.w_valid_o  = w_wr && !r_w_done;
  assign bus.aw_addr_o  = BASE_ADDR + AXI_ADDR_WIDTH'({w_reg, 3'b000});
  assign bus.w_data_o   = {32'b0, w_word};
  assign bus.w_strb_o   = 8'hFF;
  assign bus.b_ready_o  = (r_state == S_WR_RESP) || (r_state == S_CLR_RESP);
  assign bus.ar_valid_o = (r_state == S_POLL_REQ) || (r_state == S_RD_REQ);
  assign bus.ar_addr_o  = BASE_ADDR + AXI_ADDR_WIDTH'({w_rd_reg, 3'b000});
  assign bus.r_ready_o  = (r_state == S_POLL_RESP) || (r_state == S_RD_RESP);
  assign w_unused       = ^bus.r_data_i[63:32];

  assign job_ready_o = (r_state == S_IDLE) && !rst_i;
  assign done_o      = (r_state == S_DONE);
  assign err_o       = r_err;
  assign ct_o        = r_ct;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_rd_idx   <= '0;
      r_poll_cnt <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_key_sel  <= '0;
      r_key      <= '0;
      r_st       <= '0;
      r_pt       <= '0;
      r_ct_buf   <= '0;
      r_ct       <= '0;
      r_err      <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (job_valid_i) begin
          r_key_sel  <= key_sel_i;
          r_key      <= key_i;
          r_st       <= state_i;
          r_pt       <= pt_i;
          r_idx      <= '0;
          r_rd_idx   <= '0;
          r_poll_cnt <= '0;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
          r_err      <= 2'b00;
          r_ct       <= '0;
          r_state    <= S_WR_REQ;
        end
        S_WR_REQ, S_CLR_REQ: begin
          if (w_both) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_state   <= (r_state == S_WR_REQ) ? S_WR_RESP : S_CLR_RESP;
          end else begin
            if (bus.aw_valid_o && bus.aw_ready_i) r_aw_done <= 1'b1;
            if (bus.w_valid_o && bus.w_ready_i)   r_w_done  <= 1'b1;
          end
        end
        S_WR_RESP: if (bus.b_valid_i) begin
          // A failed setup write abandons the job without clearing start.
          if (bus.b_resp_i != 2'b00) begin
            r_err   <= 2'b01;
            r_state <= S_DONE;
          end else if (r_idx == 4'd15) begin
            r_state <= S_POLL_REQ;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_WR_REQ;
          end
        end
        S_POLL_REQ: if (bus.ar_ready_i) r_state <= S_POLL_RESP;
        S_POLL_RESP: if (bus.r_valid_i) begin
          if (bus.r_resp_i != 2'b00) begin
            r_err   <= 2'b10;
            r_state <= S_CLR_REQ;
          end else if (bus.r_data_i[0]) begin
            r_state <= S_RD_REQ;
          end else if (r_poll_cnt + PCW'(1) == PCW'(POLL_MAX)) begin
            r_err   <= 2'b11;
            r_state <= S_CLR_REQ;
          end else begin
            r_poll_cnt <= r_poll_cnt + PCW'(1);
            r_state    <= S_POLL_REQ;
          end
        end
        S_RD_REQ: if (bus.ar_ready_i) r_state <= S_RD_RESP;
        S_RD_RESP: if (bus.r_valid_i) begin
          if (bus.r_resp_i != 2'b00) begin
            r_err   <= 2'b10;
            r_state <= S_CLR_REQ;
          end else begin
            r_ct_buf[32*r_rd_idx +: 32] <= bus.r_data_i[31:0];
            if (r_rd_idx == 2'd3) r_state <= S_CLR_REQ;
            else begin
              r_rd_idx <= r_rd_idx + 2'd1;
              r_state  <= S_RD_REQ;
            end
          end
        end
        S_CLR_RESP: if (bus.b_valid_i) begin
          // Earlier errors take precedence over a failed start clear.
          if (bus.b_resp_i != 2'b00 && r_err == 2'b00) r_err <= 2'b01;
          r_ct    <= (r_err == 2'b00 && bus.b_resp_i == 2'b00) ? r_ct_buf : '0;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes0_cmd_initiator.sv
// Directed bench for aes0_cmd_initiator: reactive AXI4-Lite slave with programmable
// ready delays, ct_valid behaviour and BRESP fault injection, plus a bus log.
module tb_aes0_cmd_initiator;
  localparam logic [63:0] BASE = 64'h0000_0040_0000_1000;
  localparam int          PMAX = 6;
  localparam logic [191:0] KEY = 192'h00112233_44556677_8899AABB_CCDDEEFF_01234567_89ABCDEF;
  localparam logic [127:0] ST  = 128'h10203040_50607080_90A0B0C0_D0E0F000;
  localparam logic [127:0] PT  = 128'hCAFE0003_CAFE0002_CAFE0001_CAFE0000;
  localparam logic [127:0] CT  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         job_valid = 1'b0, job_ready, done;
  logic [1:0]   key_sel = '0, err;
  logic [191:0] key = '0;
  logic [127:0] st = '0, pt = '0, ct;

  aes0_cmd_initiator_if #(.AXI_ADDR_WIDTH(64)) bus();

  aes0_cmd_initiator #(.AXI_ADDR_WIDTH(64), .BASE_ADDR(BASE), .POLL_MAX(PMAX)) dut (
    .clk_i(clk), .rst_i(rst), .job_valid_i(job_valid), .job_ready_o(job_ready),
    .key_sel_i(key_sel), .key_i(key), .state_i(st), .pt_i(pt),
    .done_o(done), .err_o(err), .ct_o(ct), .bus(bus)
  );

  // slave configuration (written only by the stimulus process)
  int aw_dly = 0, w_dly = 0, poll_lo = 0, bresp_at = 0, poll_base = 0, b_base = 0;
  // slave / monitor state (written only by the monitor)
  int aw_wc = 0, w_wc = 0, b_n = 0, poll_n = 0, viol = 0, overlap = 0, strb_bad = 0;
  logic        aw_hold = 1'b0, w_hold = 1'b0;
  logic [63:0] aw_hold_a = '0, w_hold_d = '0, last_ar = '0, rdat, off;
  logic [63:0] aw_q[$], w_q[$], ar_q[$];
  logic [31:0] ctw [0:3];
  assign ctw[0] = CT[31:0];
  assign ctw[1] = CT[63:32];
  assign ctw[2] = CT[95:64];
  assign ctw[3] = CT[127:96];

  assign bus.aw_ready_i = bus.aw_valid_o && (aw_wc >= aw_dly);
  assign bus.w_ready_i  = bus.w_valid_o && (w_wc >= w_dly);
  assign bus.b_valid_i  = 1'b1;
  assign bus.b_resp_i   = (bresp_at != 0 && (b_n - b_base + 1) == bresp_at) ? 2'b10 : 2'b00;
  assign bus.ar_ready_i = 1'b1;
  assign bus.r_valid_i  = 1'b1;
  assign bus.r_resp_i   = 2'b00;
  assign bus.r_data_i   = rdat;
  assign off            = last_ar - BASE;

  always_comb begin
    rdat = {32'hDEADBEEF, 32'h0};
    if (off == 64'h58)
      rdat = {32'hDEADBEEF, 31'b0, ((poll_n - poll_base) >= poll_lo)};
    else if (off >= 64'h60 && off <= 64'h78)
      rdat = {32'hDEADBEEF, ctw[off[4:3]]};
  end

  always @(posedge clk) begin
    if (rst) begin
      aw_wc   <= 0;
      w_wc    <= 0;
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
    end else begin
      if (bus.aw_valid_o && bus.aw_ready_i) aw_q.push_back(bus.aw_addr_o);
      if (bus.w_valid_o && bus.w_ready_i)   w_q.push_back(bus.w_data_o);
      if (bus.ar_valid_o && bus.ar_ready_i) begin
        ar_q.push_back(bus.ar_addr_o);
        last_ar <= bus.ar_addr_o;
      end
      if (bus.b_valid_i && bus.b_ready_o) b_n <= b_n + 1;
      if (bus.r_valid_i && bus.r_ready_o && off == 64'h58) poll_n <= poll_n + 1;
      aw_wc <= (bus.aw_valid_o && !bus.aw_ready_i) ? aw_wc + 1 : 0;
      w_wc  <= (bus.w_valid_o && !bus.w_ready_i) ? w_wc + 1 : 0;
      if (aw_hold && (!bus.aw_valid_o || bus.aw_addr_o != aw_hold_a)) viol <= viol + 1;
      if (w_hold && (!bus.w_valid_o || bus.w_data_o != w_hold_d))     viol <= viol + 1;
      aw_hold   <= bus.aw_valid_o && !bus.aw_ready_i;
      aw_hold_a <= bus.aw_addr_o;
      w_hold    <= bus.w_valid_o && !bus.w_ready_i;
      w_hold_d  <= bus.w_data_o;
      if ((bus.aw_valid_o || bus.w_valid_o) && bus.ar_valid_o) overlap <= overlap + 1;
      if (bus.w_valid_o && bus.w_strb_o != 8'hFF) strb_bad <= strb_bad + 1;
    end
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  int a0, w0, r0, lat;

  task automatic snap();
    a0 = aw_q.size(); w0 = w_q.size(); r0 = ar_q.size();
    b_base = b_n; poll_base = poll_n;
  endtask

  task automatic run_job(input logic [1:0] ks, output int l);
    @(negedge clk);
    key_sel = ks; key = KEY; st = ST; pt = PT; job_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    l = 1;
    while (!done && l < 3000) begin
      @(negedge clk);
      l++;
    end
    chk("done_seen", 128'(done), 128'(1));
  endtask

  function automatic int count_polls(input int from);
    int n = 0;
    for (int i = from; i < ar_q.size(); i++) if (ar_q[i] == BASE + 64'h58) n++;
    return n;
  endfunction

  initial begin
    @(negedge clk);
    chk("rst_job_ready", 128'(job_ready), 128'(0));
    chk("rst_valids", 128'({bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o, bus.b_ready_o, bus.r_ready_o}), 128'(0));
    chk("rst_done_err", 128'({done, err}), 128'(0));
    chk("rst_ct", ct, 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_job_ready", 128'(job_ready), 128'(1));

    // zero-wait, key1, immediate ct_valid
    snap();
    run_job(2'b01, lat);
    chk("t1_latency", 128'(lat), 128'(45));
    chk("t1_err", 128'(err), 128'(0));
    chk("t1_ct", ct, CT);
    chk("t1_aw_n", 128'(aw_q.size() - a0), 128'(17));
    chk("t1_ar_n", 128'(ar_q.size() - r0), 128'(5));
    chk("t1_a_ksel", 128'(aw_q[a0]), 128'(BASE + 64'h100));
    chk("t1_d_ksel", 128'(w_q[w0]), 128'(64'h1));
    chk("t1_a_key0", 128'(aw_q[a0+1]), 128'(BASE + 64'hA0));
    chk("t1_d_key0", 128'(w_q[w0+1]), 128'(64'h89ABCDEF));
    chk("t1_a_key5", 128'(aw_q[a0+6]), 128'(BASE + 64'hC8));
    chk("t1_d_key5", 128'(w_q[w0+6]), 128'(64'h00112233));
    chk("t1_a_st0", 128'(aw_q[a0+7]), 128'(BASE + 64'h80));
    chk("t1_d_st0", 128'(w_q[w0+7]), 128'(64'hD0E0F000));
    chk("t1_a_pt3", 128'(aw_q[a0+14]), 128'(BASE + 64'h20));
    chk("t1_d_pt3", 128'(w_q[w0+14]), 128'(64'hCAFE0003));
    chk("t1_start", 128'({aw_q[a0+15], w_q[w0+15]}), {BASE, 64'h1});
    chk("t1_clear", 128'({aw_q[a0+16], w_q[w0+16]}), {BASE, 64'h0});
    chk("t1_poll_a", 128'(ar_q[r0]), 128'(BASE + 64'h58));
    chk("t1_rd3_a", 128'(ar_q[r0+4]), 128'(BASE + 64'h78));
    @(negedge clk);
    chk("t1_done_pulse", 128'(done), 128'(0));

    // ct_valid low for 5 polls: last allowed poll before timeout succeeds
    poll_lo = 5;
    snap();
    run_job(2'b00, lat);
    chk("t3_polls", 128'(count_polls(r0)), 128'(6));
    chk("t3_rd0_after", 128'(ar_q[r0+6]), 128'(BASE + 64'h60));
    chk("t3_err", 128'(err), 128'(0));
    chk("t3_ct", ct, CT);

    // ct_valid never set: timeout after POLL_MAX polls, clear still issued
    poll_lo = 1000;
    snap();
    run_job(2'b00, lat);
    chk("t4_polls", 128'(count_polls(r0)), 128'(PMAX));
    chk("t4_ar_n", 128'(ar_q.size() - r0), 128'(PMAX));
    chk("t4_aw_n", 128'(aw_q.size() - a0), 128'(17));
    chk("t4_clear", 128'({aw_q[a0+16], w_q[w0+16]}), {BASE, 64'h0});
    chk("t4_err", 128'(err), 128'(3));
    chk("t4_ct", ct, 128'(0));
    poll_lo = 0;

    // AW delayed, W immediate; key bank 0
    aw_dly = 3;
    snap();
    run_job(2'b00, lat);
    chk("t2a_aw_n", 128'(aw_q.size() - a0), 128'(17));
    chk("t2a_w_n", 128'(w_q.size() - w0), 128'(17));
    chk("t2a_b_n", 128'(b_n - b_base), 128'(17));
    chk("t2a_a_key0", 128'(aw_q[a0+1]), 128'(BASE + 64'h28));
    chk("t2a_ct", ct, CT);
    aw_dly = 0;

    // BRESP error on the 3rd write: stop immediately, no clear
    bresp_at = 3;
    snap();
    run_job(2'b01, lat);
    chk("t5_aw_n", 128'(aw_q.size() - a0), 128'(3));
    chk("t5_ar_n", 128'(ar_q.size() - r0), 128'(0));
    chk("t5_err", 128'(err), 128'(1));
    chk("t5_ct", ct, 128'(0));
    bresp_at = 0;

    // W delayed, AW immediate; key bank 2 via key_sel=11
    w_dly = 3;
    snap();
    run_job(2'b11, lat);
    chk("t2b_aw_n", 128'(aw_q.size() - a0), 128'(17));
    chk("t2b_b_n", 128'(b_n - b_base), 128'(17));
    chk("t2b_a_key0", 128'(aw_q[a0+1]), 128'(BASE + 64'hD0));
    chk("t2b_ct", ct, CT);
    w_dly = 0;
    chk("stable_viol", 128'(viol), 128'(0));
    chk("ar_aw_overlap", 128'(overlap), 128'(0));
    chk("strb_bad", 128'(strb_bad), 128'(0));

    // async reset in WR_REQ while AW is stalled
    aw_dly = 100;
    @(negedge clk);
    key_sel = 2'b01; job_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
    chk("t6_aw_pre", 128'(bus.aw_valid_o), 128'(1));
    #1 rst = 1'b1;
    #1;
    chk("t6_valids", 128'({bus.aw_valid_o, bus.w_valid_o, bus.ar_valid_o}), 128'(0));
    chk("t6_job_ready", 128'(job_ready), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    @(posedge clk);
    #1;
    chk("t6_ready_after", 128'(job_ready), 128'(1));
    chk("t6_out_clear", 128'({done, err, ct}), 128'(0));
    snap();
    run_job(2'b01, lat);
    chk("t6_recover_lat", 128'(lat), 128'(45));
    chk("t6_recover_ct", ct, CT);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
